// File: rtl/multi_timer.sv
//============================================================================
// Module      : multi_timer
// Description : Free-running DIV_W-bit divider shared by NCH programmable
//               timer channels (TIMA/TMA/TAC each), with per-channel
//               overflow interrupt pulses on the CPU register bus.
//               Optional feature macro: MULTI_TIMER_DIV_EVENT_EN adds the
//               div_event output (falling-edge pulse of div[EVT_BIT]).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module multi_timer #(
    parameter int DIV_W   = 16,
    parameter int NCH     = 2,
    parameter int ADDR_W  = 4,
    parameter int TAP0    = 9,
    parameter int TAP1    = 3,
    parameter int TAP2    = 5,
    parameter int TAP3    = 7,
    parameter int EVT_BIT = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic              rd,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [NCH-1:0]    irq,
`ifdef MULTI_TIMER_DIV_EVENT_EN
    output logic              div_event,
`endif
    output logic [DIV_W-1:0]  div
);

    // Channel phases: NORMAL counts, PEND is the cycle after wrap (TIMA=00),
    // LOAD is the cycle after reload where the interrupt is visible.
    localparam logic [1:0] c_st_normal = 2'd0;
    localparam logic [1:0] c_st_pend   = 2'd1;
    localparam logic [1:0] c_st_load   = 2'd2;

    localparam logic [DIV_W-1:0]  c_div_one = DIV_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_div = '0;

    logic [DIV_W-1:0] r_div;
    logic             w_div_wr;

    // Flattened per-channel registers, used by the read mux.
    logic [8*NCH-1:0] w_tima_bus;
    logic [8*NCH-1:0] w_tma_bus;
    logic [3*NCH-1:0] w_tac_bus;

    assign w_div_wr = wr & (addr == c_addr_div);
    assign div      = r_div;

    // Free-running divider; any DIV write clears it regardless of data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_div_wr) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_div_one;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [ADDR_W-1:0] c_a_tima = ADDR_W'(1 + 3*k);
        localparam logic [ADDR_W-1:0] c_a_tma  = ADDR_W'(2 + 3*k);
        localparam logic [ADDR_W-1:0] c_a_tac  = ADDR_W'(3 + 3*k);

        logic [7:0] r_tima;
        logic [7:0] r_tma;
        logic [2:0] r_tac;
        logic [1:0] r_state;
        logic       r_prev_sig;

        logic [7:0] w_tima_nxt;
        logic [1:0] w_state_nxt;
        logic       w_tap;
        logic       w_sig;
        logic       w_tick;
        logic       w_wr_tima;
        logic       w_wr_tma;
        logic       w_wr_tac;

        assign w_wr_tima = wr & (addr == c_a_tima);
        assign w_wr_tma  = wr & (addr == c_a_tma);
        assign w_wr_tac  = wr & (addr == c_a_tac);

        // Divider tap selected by TAC[1:0].
        always_comb begin
            case (r_tac[1:0])
                2'd0:    w_tap = r_div[TAP0];
                2'd1:    w_tap = r_div[TAP1];
                2'd2:    w_tap = r_div[TAP2];
                default: w_tap = r_div[TAP3];
            endcase
        end

        // Falling edge of the gated tap is the increment event; gating with
        // enable means disabling or DIV clears can also fall the signal.
        assign w_sig  = r_tac[2] & w_tap;
        assign w_tick = r_prev_sig & ~w_sig;

        // Previous gated-tap value for the edge detector.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_prev_sig <= 1'b0;
            end else begin
                r_prev_sig <= w_sig;
            end
        end

        // TMA and TAC are plain bus registers, writable in any phase.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_tma <= 8'h00;
                r_tac <= 3'b000;
            end else begin
                if (w_wr_tma) begin
                    r_tma <= din;
                end
                if (w_wr_tac) begin
                    r_tac <= din[2:0];
                end
            end
        end

        // Channel state and counter registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= c_st_normal;
                r_tima  <= 8'h00;
            end else begin
                r_state <= w_state_nxt;
                r_tima  <= w_tima_nxt;
            end
        end

        // Next-state and counter update; ticks outside NORMAL are dropped.
        always_comb begin
            w_state_nxt = r_state;
            w_tima_nxt  = r_tima;
            case (r_state)
                c_st_normal: begin
                    if (w_wr_tima) begin
                        w_tima_nxt = din;
                    end else if (w_tick) begin
                        if (r_tima == 8'hFF) begin
                            w_tima_nxt  = 8'h00;
                            w_state_nxt = c_st_pend;
                        end else begin
                            w_tima_nxt = r_tima + 8'd1;
                        end
                    end
                end
                c_st_pend: begin
                    if (w_wr_tima) begin
                        // CPU write cancels the pending reload and interrupt.
                        w_tima_nxt  = din;
                        w_state_nxt = c_st_normal;
                    end else begin
                        // A same-cycle TMA write supplies the reload value.
                        w_tima_nxt  = w_wr_tma ? din : r_tma;
                        w_state_nxt = c_st_load;
                    end
                end
                c_st_load: begin
                    // TIMA writes are ignored here, but TMA writes copy through.
                    if (w_wr_tma) begin
                        w_tima_nxt = din;
                    end
                    w_state_nxt = c_st_normal;
                end
                default: begin
                    w_state_nxt = c_st_normal;
                end
            endcase
        end

        assign irq[k]               = (r_state == c_st_load);
        assign w_tima_bus[8*k +: 8] = r_tima;
        assign w_tma_bus[8*k +: 8]  = r_tma;
        assign w_tac_bus[3*k +: 3]  = r_tac;
    end

    // Read mux; unmapped addresses and rd=0 read as zero.
    always_comb begin
        dout = 8'h00;
        if (rd) begin
            if (addr == c_addr_div) begin
                dout = r_div[DIV_W-1 -: 8];
            end
            for (int k = 0; k < NCH; k++) begin
                if (addr == ADDR_W'(1 + 3*k)) begin
                    dout = w_tima_bus[8*k +: 8];
                end
                if (addr == ADDR_W'(2 + 3*k)) begin
                    dout = w_tma_bus[8*k +: 8];
                end
                if (addr == ADDR_W'(3 + 3*k)) begin
                    dout = {5'b11111, w_tac_bus[3*k +: 3]};
                end
            end
        end
    end

`ifdef MULTI_TIMER_DIV_EVENT_EN
    logic r_evt_prev;

    // Previous divider event bit, so a DIV-write-forced fall also pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_prev <= 1'b0;
        end else begin
            r_evt_prev <= r_div[EVT_BIT];
        end
    end

    assign div_event = r_evt_prev & ~r_div[EVT_BIT];
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_timer.sv
//============================================================================
// Module      : tb_multi_timer
// Description : Self-checking bench for multi_timer with a cycle-level
//               behavioural model of divider, channels and register map.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_multi_timer;

    logic       clk;
    logic       reset;
    logic [3:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [1:0] irq;
    logic [15:0] div;
`ifdef MULTI_TIMER_DIV_EVENT_EN
    logic       div_event;
`endif

    multi_timer dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wr        (wr),
        .rd        (rd),
        .din       (din),
        .dout      (dout),
        .irq       (irq),
`ifdef MULTI_TIMER_DIV_EVENT_EN
        .div_event (div_event),
`endif
        .div       (div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model. m_age counts cycles since a wrap: 0 idle,
    // 1 = the wrap cycle (TIMA reads 00), 2 = reload cycle (irq high).
    int m_div;
    int m_tima [2];
    int m_tma  [2];
    int m_tac  [2];
    int m_age  [2];
    bit m_prev [2];
    bit m_evt_prev;

    function automatic int tap_of(int sel);
        case (sel)
            0:       return 9;
            1:       return 3;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    function automatic bit div_bit(int b);
        return bit'((m_div >> b) & 1);
    endfunction

    function automatic logic [1:0] exp_irq();
        return {m_age[1] == 2, m_age[0] == 2};
    endfunction

    function automatic int model_read(int a);
        if (a == 0) return (m_div >> 8) & 255;
        for (int k = 0; k < 2; k++) begin
            if (a == 1 + 3*k) return m_tima[k];
            if (a == 2 + 3*k) return m_tma[k];
            if (a == 3 + 3*k) return 32'hF8 | m_tac[k];
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_div = 0;
        m_evt_prev = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_tima[k] = 0; m_tma[k] = 0; m_tac[k] = 0; m_age[k] = 0; m_prev[k] = 1'b0;
        end
    endtask

    // Advances the model across one clock edge given the bus inputs.
    task automatic model_step(bit w, int a, int d);
        for (int k = 0; k < 2; k++) begin
            bit sig;
            bit tk;
            bit w_tima;
            bit w_tma;
            sig = (m_tac[k] >= 4) && div_bit(tap_of(m_tac[k] & 3));
            tk = m_prev[k] && !sig;
            m_prev[k] = sig;
            w_tima = w && (a == 1 + 3*k);
            w_tma  = w && (a == 2 + 3*k);
            if (m_age[k] == 0) begin
                if (w_tima) m_tima[k] = d;
                else if (tk) begin
                    if (m_tima[k] == 255) begin m_tima[k] = 0; m_age[k] = 1; end
                    else m_tima[k] = m_tima[k] + 1;
                end
            end else if (m_age[k] == 1) begin
                if (w_tima) begin m_tima[k] = d; m_age[k] = 0; end
                else begin m_tima[k] = w_tma ? d : m_tma[k]; m_age[k] = 2; end
            end else begin
                if (w_tma) m_tima[k] = d;
                m_age[k] = 0;
            end
            if (w_tma) m_tma[k] = d;
            if (w && (a == 3 + 3*k)) m_tac[k] = d & 7;
        end
        m_evt_prev = div_bit(12);
        m_div = (w && a == 0) ? 0 : ((m_div + 1) & 16'hFFFF);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int a, input int exp);
        rd = 1'b1;
        addr = a[3:0];
        #1;
        chk(tag, {24'h0, dout}, exp);
        rd = 1'b0;
        addr = 4'h0;
    endtask

    // One clock with the given bus write (w=0 for idle); checks irq/div after.
    task automatic cyc(input bit w, input int a, input int d);
        wr = w; addr = a[3:0]; din = d[7:0]; rd = 1'b0;
        model_step(w, a, d);
        @(posedge clk);
        #1;
        wr = 1'b0; addr = 4'h0; din = 8'h00;
        chk("irq", {30'h0, irq}, {30'h0, exp_irq()});
        chk("div", {16'h0, div}, m_div);
`ifdef MULTI_TIMER_DIV_EVENT_EN
        chk("div_event", {31'h0, div_event}, {31'h0, m_evt_prev & !div_bit(12)});
`endif
    endtask

    task automatic wait_age(input int k, input int age);
        for (int i = 0; i < 600 && m_age[k] != age; i++) cyc(1'b0, 0, 0);
        if (m_age[k] != age) begin
            n_assert++;
            n_fail++;
            $error("FAIL wait_age: observed=%0d expected=%0d", m_age[k], age);
        end
    endtask

    task automatic wait_div_low(input int val);
        for (int i = 0; i < 40 && (m_div & 15) != val; i++) cyc(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_div", {16'h0, div}, 0);
        chk("rst_irq", {30'h0, irq}, 0);
        rd_chk("rst_dout_div", 0, 0);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = 4'h0; din = 8'h00;
        model_reset();
        #3;
        chk("init_div", {16'h0, div}, 0);
        chk("init_irq", {30'h0, irq}, 0);
        rd_chk("init_dout", 1, 0);
        #9 reset = 1'b0;

        // Reset and divider: reset mid-count, then 256 clocks.
        for (int i = 0; i < 37; i++) cyc(1'b0, 0, 0);
        do_reset();
        for (int i = 0; i < 256; i++) cyc(1'b0, 0, 0);
        chk("div_256", {16'h0, div}, 32'h0100);
        rd_chk("div_read", 0, 1);
        rd = 1'b0; addr = 4'h1; #1;
        chk("rd_low_zero", {24'h0, dout}, 0);
        addr = 4'h0;

        // Tick rate on ch0 using tap bit 3.
        cyc(1'b1, 1, 0);
        cyc(1'b1, 3, 5);
        for (int i = 0; i < 300; i++) cyc(1'b0, 0, 0);
        rd_chk("tick_tima", 1, model_read(1));
        rd_chk("tick_tac", 3, 32'hFD);

        // Overflow timing on ch1.
        cyc(1'b1, 3, 0);
        cyc(1'b1, 6, 0);
        cyc(1'b1, 5, 8'hFE);
        cyc(1'b1, 4, 8'hFF);
        cyc(1'b1, 6, 5);
        wait_age(1, 1);
        rd_chk("ovf_pend_tima", 4, 0);
        cyc(1'b0, 0, 0);
        chk("ovf_irq_load", {30'h0, irq}, 2);
        rd_chk("ovf_reload", 4, 8'hFE);
        cyc(1'b0, 0, 0);
        chk("ovf_irq_clear", {30'h0, irq}, 0);

        // Overflow cancelled by a TIMA write in the wrap cycle.
        cyc(1'b1, 4, 8'hFF);
        wait_age(1, 1);
        cyc(1'b1, 4, 8'h40);
        rd_chk("cancel_tima", 4, 8'h40);
        cyc(1'b0, 0, 0);
        chk("cancel_no_irq", {31'h0, irq[1]}, 0);

        // TMA write during the reload cycle copies into TIMA.
        cyc(1'b1, 4, 8'hFF);
        wait_age(1, 1);
        cyc(1'b0, 0, 0);
        chk("load_irq", {30'h0, irq}, 2);
        cyc(1'b1, 5, 8'h33);
        rd_chk("load_tima", 4, 8'h33);
        rd_chk("load_tma", 5, 8'h33);

        // DIV write while the selected bit is 1 creates a tick.
        cyc(1'b1, 6, 0);
        cyc(1'b1, 3, 5);
        wait_div_low(8);
        cyc(1'b1, 1, 7);
        cyc(1'b1, 0, 8'h5A);
        chk("glitch_div", {16'h0, div}, 0);
        cyc(1'b0, 0, 0);
        rd_chk("glitch_tima", 1, 8'h08);

        // Same with the selected bit at 0: no tick.
        wait_div_low(0);
        cyc(1'b1, 1, 7);
        cyc(1'b1, 0, 0);
        cyc(1'b0, 0, 0);
        rd_chk("noglitch_tima", 1, 8'h07);

`ifdef MULTI_TIMER_DIV_EVENT_EN
        for (int i = 0; i < 5000 && !div_bit(12); i++) cyc(1'b0, 0, 0);
        cyc(1'b1, 0, 0);
        chk("evt_pulse", {31'h0, div_event}, 1);
        cyc(1'b0, 0, 0);
        chk("evt_once", {31'h0, div_event}, 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int a;
            int d;
            r = int'($urandom_range(0, 99));
            a = int'($urandom_range(1, 6));
            d = int'($urandom_range(0, 255));
            if (a == 1 || a == 4) begin
                if ($urandom_range(0, 1) == 1) d = 8'hF0 | (d & 15);
            end
            if (r < 2) cyc(1'b1, 0, d);
            else if (r < 20) cyc(1'b1, a, d);
            else cyc(1'b0, 0, 0);
            if ((i % 3) == 0) begin
                a = int'($urandom_range(0, 15));
                rd_chk("rand_rd", a, model_read(a));
            end
        end

        // Reset during the wrap cycle aborts the reload and interrupt.
        cyc(1'b1, 6, 5);
        cyc(1'b1, 4, 8'hFF);
        wait_age(1, 1);
        do_reset();
        rd_chk("rst_tima1", 4, 0);
        rd_chk("rst_tma1", 5, 0);
        rd_chk("rst_tac1", 6, 32'hF8);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0);
        chk("rst_no_irq", {30'h0, irq}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised successor to the fixed DIV/TIMA timer: one free-running divider of DIV_W bits shared by NCH independent programmable timer channels.
- Each channel has a counter (TIMA), a reload register (TMA) and a control register (TAC), and issues an interrupt pulse on overflow.
- Sits on the CPU register bus, clocked at the 4 MHz system clock, alongside the clock/reset block.

Parameters:
- DIV_W, 16, divider width (>=10)
- NCH, 2, number of timer channels (1..4)
- ADDR_W, 4, register address width
- TAP0, 9, divider bit selected by TAC[1:0]=0
- TAP1, 3, divider bit selected by TAC[1:0]=1
- TAP2, 5, divider bit selected by TAC[1:0]=2
- TAP3, 7, divider bit selected by TAC[1:0]=3
- EVT_BIT, 12, divider bit driving div_event (optional feature only)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- addr  input  ADDR_W  register address
- wr  input  1  write strobe, one clk per write
- rd  input  1  read enable
- din  input  8  write data
- dout  output  8  read data, combinational from current state
- irq  output  NCH  per-channel overflow pulse, one clk wide
- div  output  DIV_W  raw divider value
- div_event  output  1  falling-edge pulse of div[EVT_BIT] (optional feature only)

Behaviour:
- Reset (async): div=0; all TIMA, TMA and TAC = 0; all channels in NORMAL; prev_sig=0; irq=0; dout=0; div_event=0.
- Divider: div increments by 1 every clk and wraps at 2^DIV_W-1 -> 0.
- Register map:
  - addr 0 = DIV: reads div[DIV_W-1:DIV_W-8]; any write sets div=0 at that edge, ignoring din.
  - Channel k: addr 1+3k = TIMA, 2+3k = TMA, 3+3k = TAC.
  - TAC[2] = enable, TAC[1:0] = tap select; TAC reads back as {5'b11111, TAC[2:0]}.
- dout = selected register when rd=1 and addr is mapped; otherwise 0.
- Increment detect, per channel:
  - sig = TAC[2] & div[TAPsel], evaluated on current state.
  - prev_sig is registered each clk.
  - tick = prev_sig & !sig.
- Consequences of the detector, all intended:
  - A DIV write while the selected bit is 1 produces a tick.
  - Clearing enable while the selected bit is 1 produces a tick.
  - Changing the tap from a 1 bit to a 0 bit produces a tick.
- Channel FSM:
  - NORMAL:
    - A tick with TIMA<FF gives TIMA+1.
    - A tick with TIMA=FF gives TIMA=00 and moves to PEND.
    - A TIMA write loads din; a write coinciding with a tick wins and the tick is dropped.
  - PEND (1 clk): TIMA reads 00.
    - Next edge: TIMA=TMA and moves to LOAD.
    - A TIMA write in PEND loads din, returns to NORMAL and cancels the reload and irq.
  - LOAD (1 clk): irq[k]=1; TIMA writes are ignored.
    - A TMA write in LOAD updates TMA, and TIMA also takes din at that edge.
    - Then returns to NORMAL.
  - Ticks arriving in PEND or LOAD are dropped.
  - TMA writes in NORMAL or PEND only update TMA; in PEND the new value is the one reloaded.
- Channels are fully independent; simultaneous overflows assert multiple irq bits in the same clk.
- Reset mid-operation aborts PEND/LOAD immediately: no irq, all state zero.

Optional Feature:
- Macro MULTI_TIMER_DIV_EVENT_EN.
- Defined:
  - Adds the div_event port: 1-clk pulse when div[EVT_BIT] falls, including a fall forced by a DIV write.
  - The pulse uses its own registered previous bit, reset to 0.
- Undefined: port absent, no extra logic; all other behaviour is identical.

Test Plan:
- Reset and divider:
  - Stimulus: assert reset mid-count, release, run 256 clk.
  - Required: div=0x0100; DIV read returns 0x01; all irq low throughout.
- Tick rate:
  - Stimulus: ch0 TAC=0x05 (tap bit 3), TIMA=0.
  - Required: TIMA increments once every 16 clk; TIMA=0x10 after 256 clk from the first div[3] fall.
- Overflow timing:
  - Stimulus: ch1 TMA=0xFE, TIMA=0xFF, TAC=0x05, wait for a tick.
  - Required: TIMA reads 00 for 1 clk, then 0xFE; irq[1] high exactly in that second clk.
- Overflow cancel:
  - Stimulus: same setup as the overflow test, but write TIMA=0x40 during PEND.
  - Required: TIMA=0x40; no irq; a subsequent write in LOAD is not applicable.
- TMA write in LOAD:
  - Stimulus: write TMA=0x33 during LOAD.
  - Required: TIMA=0x33 and TMA=0x33.
- DIV-write glitch:
  - Stimulus: TAC=0x05 with div[3]=1, TIMA=0x07, write DIV.
  - Required: TIMA=0x08 next clk, div=0.
  - Repeat with div[3]=0: TIMA stays 0x07.
  - With MULTI_TIMER_DIV_EVENT_EN defined and div[12]=1: div_event pulses once.
